// File: rtl/trapezoid_feeder.sv
// trapezoid_feeder: transmit side of the trapezoid engine command port.
// Upstream {x,y} vertex beats are buffered in a FIFO and issued four at a time
// on nt/xi/yi. A new trapezoid starts only when the engine's busy is low, and
// busy is ignored for GUARD cycles after each trapezoid because the engine is
// slow to raise it.
// Optional build macro TRAP_FEED_CHECK_EN: before launching, the four head
// entries are checked and a malformed group (y0!=y1, y2!=y3 or y0>y2) is
// discarded in one cycle with a one-cycle err_malformed pulse.
module trapezoid_feeder #(
  parameter int DEPTH_TRAP = 4,
  parameter int GUARD      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           vtx_valid,
  output logic                           vtx_ready,
  input  logic [7:0]                     vtx_x,
  input  logic [7:0]                     vtx_y,
  input  logic                           busy,
  output logic                           nt,
  output logic [7:0]                     xi,
  output logic [7:0]                     yi,
  output logic [$clog2(4*DEPTH_TRAP):0]  fifo_level,
  output logic [CNT_W-1:0]               issued_cnt,
  output logic                           idle,
  output logic                           err_malformed
);

  localparam int DEPTH  = 4 * DEPTH_TRAP;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int GCNT_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } vertex_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_GUARD
  } state_e;

  vertex_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  state_e             state;
  logic [GCNT_W-1:0]  guard_cnt;
  logic               push;
  logic [2:0]         pop_n;
  logic               launch_ok;
  logic               malformed;
  vertex_t            head0;

  // Advance a FIFO pointer by k entries, wrapping modulo DEPTH (k <= 4 <= DEPTH).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Ready depends only on the registered level: a pop this cycle does not
  // make room for a push in the same cycle.
  assign vtx_ready = (fifo_level < LVL_W'(DEPTH));
  assign push      = vtx_valid && vtx_ready;
  assign head0     = mem[rd_ptr];
  assign launch_ok = (state == ST_IDLE) && !busy && (fifo_level >= LVL_W'(4));
  assign idle      = (state == ST_IDLE) && (fifo_level < LVL_W'(4));

`ifdef TRAP_FEED_CHECK_EN
  vertex_t head1, head2, head3;

  assign head1     = mem[ptr_add(rd_ptr, 1)];
  assign head2     = mem[ptr_add(rd_ptr, 2)];
  assign head3     = mem[ptr_add(rd_ptr, 3)];
  assign malformed = (head0.y != head1.y) || (head2.y != head3.y) || (head0.y > head2.y);

  // Pulse for one cycle whenever a malformed group is discarded.
  always_ff @(posedge clk) begin
    if (reset) err_malformed <= 1'b0;
    else       err_malformed <= launch_ok && malformed;
  end
`else
  assign malformed     = 1'b0;
  assign err_malformed = 1'b0;
`endif

  // Number of entries leaving the FIFO this cycle: one per issued vertex,
  // or a whole group at once when it is discarded.
  always_comb begin
    // NOTE: default assignment first so no path leaves pop_n unassigned (no latch).
    pop_n = 3'd0;
    case (state)
      ST_IDLE:             if (launch_ok) pop_n = malformed ? 3'd4 : 3'd1;
      ST_S0, ST_S1, ST_S2: pop_n = 3'd1;
      default:             pop_n = 3'd0;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= ptr_add(wr_ptr, 1);
      rd_ptr     <= ptr_add(rd_ptr, int'(pop_n));
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop_n);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read after being written,
    // and reset empties the FIFO through the pointers and level alone.
    if (push) mem[wr_ptr] <= '{x: vtx_x, y: vtx_y};
  end

  // Issue sequencer: four vertex cycles, one clearing cycle, then the guard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      nt         <= 1'b0;
      xi         <= '0;
      yi         <= '0;
      issued_cnt <= '0;
      guard_cnt  <= '0;
    end else begin
      nt <= 1'b0;
      case (state)
        ST_IDLE: begin
          xi <= '0;
          yi <= '0;
          if (launch_ok && !malformed) begin
            nt    <= 1'b1;
            xi    <= head0.x;
            yi    <= head0.y;
            state <= ST_S0;
          end
        end
        ST_S0: begin
          xi    <= head0.x;
          yi    <= head0.y;
          state <= ST_S1;
        end
        ST_S1: begin
          xi    <= head0.x;
          yi    <= head0.y;
          state <= ST_S2;
        end
        ST_S2: begin
          xi    <= head0.x;
          yi    <= head0.y;
          state <= ST_S3;
        end
        ST_S3: begin
          xi         <= '0;
          yi         <= '0;
          issued_cnt <= issued_cnt + CNT_W'(1);
          if (GUARD == 0) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_GUARD;
            guard_cnt <= GCNT_W'(GUARD);
          end
        end
        ST_GUARD: begin
          // Spend exactly GUARD cycles here; busy is not looked at.
          xi        <= '0;
          yi        <= '0;
          guard_cnt <= guard_cnt - 1'b1;
          if (guard_cnt <= GCNT_W'(1)) state <= ST_IDLE;
        end
        default: begin
          xi    <= '0;
          yi    <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trapezoid_feeder.sv
// Bench for trapezoid_feeder: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
// Build with +define+TRAP_FEED_CHECK_EN to exercise the malformed-group drop.
module tb_trapezoid_feeder;

  localparam int DEPTH_TRAP = 4;
  localparam int GUARD      = 2;
  localparam int CNT_W      = 16;
  localparam int DEPTH      = 4 * DEPTH_TRAP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vtx_valid = 1'b0;
  logic        vtx_ready;
  logic [7:0]  vtx_x = '0;
  logic [7:0]  vtx_y = '0;
  logic        busy = 1'b0;
  logic        nt;
  logic [7:0]  xi;
  logic [7:0]  yi;
  logic [4:0]  fifo_level;
  logic [15:0] issued_cnt;
  logic        idle;
  logic        err_malformed;

  always #5 clk = ~clk;

  trapezoid_feeder #(
    .DEPTH_TRAP(DEPTH_TRAP),
    .GUARD     (GUARD),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vtx_valid    (vtx_valid),
    .vtx_ready    (vtx_ready),
    .vtx_x        (vtx_x),
    .vtx_y        (vtx_y),
    .busy         (busy),
    .nt           (nt),
    .xi           (xi),
    .yi           (yi),
    .fifo_level   (fifo_level),
    .issued_cnt   (issued_cnt),
    .idle         (idle),
    .err_malformed(err_malformed)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q holds buffered beats; sched lists what the port does on each coming edge
  // once a trapezoid has been launched (an empty schedule means "ready to launch").
  typedef enum int {T_VTX, T_DONE, T_WAIT} tok_e;
  tok_e        sched[$];
  logic [15:0] q[$];
  logic        m_nt  = 1'b0;
  logic [7:0]  m_xi  = '0;
  logic [7:0]  m_yi  = '0;
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0;

`ifdef TRAP_FEED_CHECK_EN
  function automatic bit bad_group(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d);
    return (a[7:0] != b[7:0]) || (c[7:0] != d[7:0]) || (a[7:0] > c[7:0]);
  endfunction
`endif

  always @(posedge clk) begin
    logic [15:0] v;
    tok_e        t;
    bit          do_push;
    if (reset) begin
      q.delete();
      sched.delete();
      m_nt = 1'b0; m_xi = '0; m_yi = '0; m_cnt = '0; m_err = 1'b0;
    end else begin
      do_push = vtx_valid && (q.size() < DEPTH);
      m_err = 1'b0; m_nt = 1'b0; m_xi = '0; m_yi = '0;
      if (sched.size() != 0) begin
        t = sched.pop_front();
        if (t == T_VTX) begin
          v = q.pop_front();
          m_xi = v[15:8];
          m_yi = v[7:0];
        end else if (t == T_DONE) begin
          m_cnt = m_cnt + 16'd1;
        end
      end else if (!busy && q.size() >= 4) begin
`ifdef TRAP_FEED_CHECK_EN
        if (bad_group(q[0], q[1], q[2], q[3])) begin
          repeat (4) void'(q.pop_front());
          m_err = 1'b1;
        end else
`endif
        begin
          v = q.pop_front();
          m_nt = 1'b1;
          m_xi = v[15:8];
          m_yi = v[7:0];
          sched.push_back(T_VTX);
          sched.push_back(T_VTX);
          sched.push_back(T_VTX);
          sched.push_back(T_DONE);
          for (int i = 0; i < GUARD; i++) sched.push_back(T_WAIT);
        end
      end
      if (do_push) q.push_back({vtx_x, vtx_y});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("nt", nt, m_nt);
      check("xi", xi, m_xi);
      check("yi", yi, m_yi);
      check("issued_cnt", issued_cnt, m_cnt);
      check("fifo_level", fifo_level, q.size());
      check("vtx_ready", vtx_ready, q.size() < DEPTH);
      check("idle", idle, (sched.size() == 0) && (q.size() < 4));
      check("err_malformed", err_malformed, m_err);
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_beat(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    vtx_valid = 1'b1;
    vtx_x = x;
    vtx_y = y;
    while (!vtx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!vtx_ready) check("push_timeout", vtx_ready, 1);
    @(negedge clk);
    vtx_valid = 1'b0;
  endtask

  task automatic wait_nt(input string tag);
    int n = 0;
    while (nt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, nt, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(idle === 1'b1 && fifo_level == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, fifo_level, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nts;
    int          verts;
    int          second;
    int          busy_run;
    int          bi;
    bit          acc;
    logic [15:0] grp [4];

    // Reset state
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_nt", nt, 0);
    check("rst_xi", xi, 0);
    check("rst_level", fifo_level, 0);
    check("rst_cnt", issued_cnt, 0);
    check("rst_idle", idle, 1);
    check("rst_ready", vtx_ready, 1);
    check("rst_err", err_malformed, 0);

    // 1: single trapezoid, literal vertex sequence
    busy = 1'b0;
    push_beat(8'h10, 8'h05);
    push_beat(8'h30, 8'h05);
    push_beat(8'h08, 8'h20);
    push_beat(8'h40, 8'h20);
    wait_nt("t1_nt");
    check("t1_x0", xi, 8'h10); check("t1_y0", yi, 8'h05);
    cyc(1);
    check("t1_nt1", nt, 0); check("t1_x1", xi, 8'h30); check("t1_y1", yi, 8'h05);
    cyc(1);
    check("t1_x2", xi, 8'h08); check("t1_y2", yi, 8'h20);
    cyc(1);
    check("t1_x3", xi, 8'h40); check("t1_y3", yi, 8'h20);
    cyc(2);
    check("t1_xclr", xi, 0);
    check("t1_cnt", issued_cnt, 1);
    wait_drain("t1_drain");

    // 2: two trapezoids, busy held high for 50 cycles after the first issue
    busy = 1'b1;
    for (int i = 0; i < 8; i++) push_beat(8'(8'h21 + i), (i % 4 < 2) ? 8'h40 : 8'h50);
    busy = 1'b0;
    wait_nt("t2_first_nt");
    busy = 1'b1;
    nts = 1; verts = 1; second = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if ({xi, yi} != 16'h0) verts++;
      if (nt) begin
        nts++;
        if (second < 0) second = i;
      end
      if (i == 50) busy = 1'b0;
    end
    check("t2_nt_count", nts, 2);
    check("t2_vertex_cycles", verts, 8);
    check("t2_second_nt_cycle", second, 51);
    wait_drain("t2_drain");

    // 3: fill the FIFO while busy, reject an extra beat, ready after first pop
    busy = 1'b1;
    for (int i = 0; i < 16; i++) push_beat(8'(8'h60 + i), (i % 4 < 2) ? 8'h20 : 8'h30);
    vtx_valid = 1'b1; vtx_x = 8'hEE; vtx_y = 8'hEE;
    cyc(3);
    check("t3_level_full", fifo_level, 16);
    check("t3_ready_full", vtx_ready, 0);
    vtx_valid = 1'b0;
    busy = 1'b0;
    cyc(1);
    check("t3_ready_back", vtx_ready, 1);
    check("t3_level_pop", fifo_level, 15);
    wait_drain("t3_drain");

    // 4: partial group waits; fourth beat launches at the next edge
    busy = 1'b0;
    push_beat(8'h11, 8'h12);
    push_beat(8'h13, 8'h12);
    push_beat(8'h14, 8'h22);
    nts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (nt) nts++;
    end
    check("t4_no_nt", nts, 0);
    check("t4_idle", idle, 1);
    check("t4_level", fifo_level, 3);
    push_beat(8'h15, 8'h22);
    check("t4_nt_not_yet", nt, 0);
    cyc(1);
    check("t4_nt", nt, 1);
    check("t4_xi", xi, 8'h11);
    check("t4_yi", yi, 8'h12);
    wait_drain("t4_drain");

    // 5: reset in the middle of a transfer
    busy = 1'b1;
    for (int i = 0; i < 8; i++) push_beat(8'(8'h70 + i), (i % 4 < 2) ? 8'h44 : 8'h48);
    busy = 1'b0;
    wait_nt("t5_nt");
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t5_nt", nt, 0);
    check("t5_xi", xi, 0);
    check("t5_yi", yi, 0);
    check("t5_level", fifo_level, 0);
    check("t5_cnt", issued_cnt, 0);

    // 6: group with y0 != y1
    busy = 1'b1;
    push_beat(8'h10, 8'h05);
    push_beat(8'h30, 8'h06);
    push_beat(8'h08, 8'h20);
    push_beat(8'h40, 8'h20);
    check("t6_level", fifo_level, 4);
    busy = 1'b0;
    cyc(1);
`ifdef TRAP_FEED_CHECK_EN
    check("t6_err", err_malformed, 1);
    check("t6_nt", nt, 0);
    check("t6_level_dropped", fifo_level, 0);
    cyc(1);
    check("t6_err_pulse", err_malformed, 0);
`else
    check("t6_nt", nt, 1);
    check("t6_xi", xi, 8'h10);
    check("t6_yi", yi, 8'h05);
    wait_drain("t6_drain");
`endif

    // Randomized traffic: mostly well-formed groups, random valid/busy, rare resets
    busy_run = 0;
    bi = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bi == 0) begin
        logic [7:0] yu;
        logic [7:0] yd;
        yu = 8'($urandom_range(0, 200));
        yd = 8'(yu + 8'($urandom_range(0, 55)));
        grp[0] = {8'($urandom_range(1, 255)), yu};
        grp[1] = {8'($urandom_range(1, 255)), yu};
        grp[2] = {8'($urandom_range(1, 255)), yd};
        grp[3] = {8'($urandom_range(1, 255)), yd};
        if ($urandom_range(0, 7) == 0) grp[1][7:0] = grp[1][7:0] ^ 8'h01;
      end
      if (busy_run == 0) begin
        busy = ($urandom_range(0, 2) == 0);
        busy_run = $urandom_range(1, 30);
      end else begin
        busy_run--;
      end
      reset = ($urandom_range(0, 799) == 0);
      vtx_valid = ($urandom_range(0, 3) != 0);
      vtx_x = grp[bi][15:8];
      vtx_y = grp[bi][7:0];
      acc = vtx_valid && vtx_ready && !reset;
      @(negedge clk);
      if (reset) bi = 0;
      else if (acc) bi = (bi + 1) % 4;
    end
    reset = 1'b0;
    vtx_valid = 1'b0;
    busy = 1'b0;
    cyc(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
